data_mem_lsu: RTL and testbench

- Initiator-side load/store sequencer for the 4-lane byte-enabled data RAM (12-bit byte address space, 1-cycle registered read).
- Accepts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests from the core, drives word address / lane data / per-lane write enables, and returns the loaded value with alignment and sign/zero extension applied.
- Sits between the core's memory stage and the byte-lane RAM.

---
 rtl/data_mem_lsu.sv | 242 ++++++++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// Load/store sequencer for a 4-lane byte-enabled RAM; store 2 / load 3 / error 1 cycles from accept, RESP holds until resp_ready.
// `define LSU_MISALIGN_EN to split word-crossing accesses into two RAM cycles instead of raising resp_err.
module data_mem_lsu #(
  parameter int AW = 12
) (
  input  logic        clk_20M,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
`ifdef LSU_MISALIGN_EN
    , S_ISSUE2,
    S_CAPTURE2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        req_mis;
`ifdef LSU_MISALIGN_EN
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic        cross_q, cross_d;
`endif

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    if (we) bad = f3[2] || (f3[1:0] == 2'b11);
    else    bad = (f3[1:0] == 2'b11) || (f3 == 3'b110);
    return bad;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] o);
    return ((sz == 2'b01) && o[0]) || ((sz == 2'b10) && (o != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] o,
                                           input logic hi);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0f;
    endcase
    m = m << o;
    return hi ? m[7:4] : m[3:0];
  endfunction

  // Aligned stores replicate the datum so every candidate lane carries it.
  function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [63:0] win);
    logic [31:0] sh;
    logic [31:0] r;
    sh = 32'(win >> {o, 3'b000});
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b100:  r = {24'b0, sh[7:0]};
      3'b101:  r = {16'b0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_EN
  function automatic logic is_crossing(input logic [1:0] sz, input logic [1:0] o);
    return ((sz == 2'b01) && (o == 2'b11)) || ((sz == 2'b10) && (o != 2'b00));
  endfunction

  // Misaligned store data is shifted across an 8-byte window {word B, word A}.
  function automatic logic [31:0] lane_shift(input logic [1:0] sz, input logic [1:0] o,
                                             input logic [31:0] wd, input logic hi);
    logic [63:0] sh;
    sh = (sz == 2'b01) ? {48'b0, wd[15:0]} : {32'b0, wd};
    sh = sh << {o, 3'b000};
    return hi ? sh[63:32] : sh[31:0];
  endfunction

  assign req_mis = 1'b0;
`else
  assign req_mis = is_misaligned(req_funct3[1:0], req_addr[1:0]);
`endif

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef LSU_MISALIGN_EN
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    cross_d      = cross_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d         = req_we;
          f3_d         = req_funct3;
          off_d        = req_addr[1:0];
          resp_rdata_d = 32'b0;
          resp_err_d   = 1'b0;
`ifdef LSU_MISALIGN_EN
          wdata_d      = req_wdata;
          cross_d      = is_crossing(req_funct3[1:0], req_addr[1:0]);
`endif
          if (is_illegal(req_we, req_funct3) || req_mis) begin
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end else begin
            mem_addr_d  = {req_addr[31:AW], req_addr[AW-1:2], 2'b00};
            mem_wdata_d = lane_rep(req_funct3[1:0], req_wdata);
`ifdef LSU_MISALIGN_EN
            if (is_misaligned(req_funct3[1:0], req_addr[1:0]))
              mem_wdata_d = lane_shift(req_funct3[1:0], req_addr[1:0], req_wdata, 1'b0);
`endif
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = we_q ? S_RESP : S_CAPTURE;
`ifdef LSU_MISALIGN_EN
        if (cross_q && we_q) begin
          mem_addr_d  = mem_addr_q + 32'd4;
          mem_wdata_d = lane_shift(f3_q[1:0], off_q, wdata_q, 1'b1);
          state_d     = S_ISSUE2;
        end
`endif
      end
      S_CAPTURE: begin
        resp_rdata_d = load_ext(f3_q, off_q, {32'b0, mem_rdata});
        state_d      = S_RESP;
`ifdef LSU_MISALIGN_EN
        if (cross_q) begin
          resp_rdata_d = resp_rdata_q;
          lo_d         = mem_rdata;
          mem_addr_d   = mem_addr_q + 32'd4;
          state_d      = S_ISSUE2;
        end
`endif
      end
`ifdef LSU_MISALIGN_EN
      S_ISSUE2: state_d = we_q ? S_RESP : S_CAPTURE2;
      S_CAPTURE2: begin
        resp_rdata_d = load_ext(f3_q, off_q, {mem_rdata, lo_q});
        state_d      = S_RESP;
      end
`endif
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write enables decode straight from the state register so reset kills them at once.
  always_comb begin
    mem_wren = 4'b0000;
    if ((state_q == S_ISSUE) && we_q) mem_wren = lane_mask(f3_q[1:0], off_q, 1'b0);
`ifdef LSU_MISALIGN_EN
    if ((state_q == S_ISSUE2) && we_q) mem_wren = lane_mask(f3_q[1:0], off_q, 1'b1);
`endif
  end

  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b0;
      off_q        <= 2'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= 32'b0;
      mem_wdata_q  <= 32'b0;
`ifdef LSU_MISALIGN_EN
      wdata_q      <= 32'b0;
      lo_q         <= 32'b0;
      cross_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef LSU_MISALIGN_EN
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      cross_q      <= cross_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: table of load/store vectors against a byte-lane RAM model,
// plus hand-written backpressure and mid-transaction reset sequences.
module tb_data_mem_lsu;

  logic        clk_20M = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wren;

  always #25 clk_20M = ~clk_20M;

  data_mem_lsu #(.AW(12)) dut (
    .clk_20M(clk_20M), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );

  // Byte-lane RAM with one-cycle registered read.
  logic [31:0] ram [0:1023];
  always @(posedge clk_20M) begin
    for (int k = 0; k < 4; k++)
      if (mem_wren[k]) ram[mem_addr[11:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
    mem_rdata <= ram[mem_addr[11:2]];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_wren;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    logic [3:0]  wr_seen;
    logic [31:0] wd, ad;
    @(negedge clk_20M);
    check($sformatf("v%0d_req_ready", idx), {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(negedge clk_20M);
    req_valid = 1'b0;
    lat = 1; wr_seen = 4'b0; wd = 32'b0; ad = 32'b0;
    while (!resp_valid && lat < 20) begin
      wr_seen |= mem_wren;
      if (mem_wren != 4'b0) begin
        wd = mem_wdata;
        ad = mem_addr;
      end
      @(negedge clk_20M);
      lat++;
    end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
    check($sformatf("v%0d_err", idx), {31'b0, resp_err}, {31'b0, v.exp_err});
    check($sformatf("v%0d_wren", idx), {28'b0, wr_seen}, {28'b0, v.exp_wren});
    if (v.exp_wren != 4'b0) begin
      check($sformatf("v%0d_mem_wdata", idx), wd, v.exp_wdata);
      check($sformatf("v%0d_mem_addr", idx), ad, v.exp_addr);
    end
  endtask

  initial begin
    vec_t vq[$];
    vec_t v;
    int   n;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0; resp_ready = 1'b1;
    #60;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_wren", {28'b0, mem_wren}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk_20M);
    rst_n = 1'b1;

    //             we    f3      addr        wdata          rdata         err  lat wren   mem_wdata      mem_addr
    vq.push_back('{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 4'hF, 32'hDEADBEEF, 32'h100});
    vq.push_back('{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h00000000, 1'b0, 2, 4'h8, 32'hA5A5A5A5, 32'h100});
    vq.push_back('{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFA5, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b100, 32'h103, 32'h0,        32'h000000A5, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hA5ADBEEF, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b010, 32'h200, 32'h80017FFF, 32'h00000000, 1'b0, 2, 4'hF, 32'h80017FFF, 32'h200});
    vq.push_back('{1'b0, 3'b001, 32'h202, 32'h0,        32'hFFFF8001, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b101, 32'h200, 32'h0,        32'h00007FFF, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b001, 32'h200, 32'h0,        32'h00007FFF, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b001, 32'h102, 32'h1234CAFE, 32'h00000000, 1'b0, 2, 4'hC, 32'hCAFECAFE, 32'h100});
    vq.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hCAFEBEEF, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFBE, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b100, 32'h102, 32'h0,        32'h000000FE, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b000, 32'h201, 32'hFFFFFF7E, 32'h00000000, 1'b0, 2, 4'h2, 32'h7E7E7E7E, 32'h200});
    vq.push_back('{1'b0, 3'b010, 32'h200, 32'h0,        32'h80017EFF, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b000, 32'h201, 32'h0,        32'h0000007E, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    // Illegal funct3 codes: error in one cycle, no RAM cycle.
    vq.push_back('{1'b0, 3'b011, 32'h100, 32'h0,        32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b110, 32'h100, 32'h0,        32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b100, 32'h100, 32'h11111111, 32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b011, 32'h100, 32'h22222222, 32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hCAFEBEEF, 1'b0, 3, 4'h0, 32'h0,        32'h0});
`ifdef LSU_MISALIGN_EN
    vq.push_back('{1'b1, 3'b010, 32'h100, 32'h44332211, 32'h00000000, 1'b0, 2, 4'hF, 32'h44332211, 32'h100});
    vq.push_back('{1'b1, 3'b010, 32'h104, 32'h88776655, 32'h00000000, 1'b0, 2, 4'hF, 32'h88776655, 32'h104});
    vq.push_back('{1'b0, 3'b010, 32'h101, 32'h0,        32'h55443322, 1'b0, 5, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b001, 32'h103, 32'h0000BBAA, 32'h00000000, 1'b0, 3, 4'h9, 32'h000000BB, 32'h104});
    vq.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hAA332211, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b010, 32'h104, 32'h0,        32'h887766BB, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b101, 32'h103, 32'h0,        32'h0000BBAA, 1'b0, 5, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b001, 32'h101, 32'h0,        32'h00003322, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h00000000, 1'b0, 2, 4'h6, 32'h00BEEF00, 32'h100});
    vq.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hAABEEF11, 1'b0, 3, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b010, 32'h103, 32'h0,        32'h7766BBAA, 1'b0, 5, 4'h0, 32'h0,        32'h0});
`else
    vq.push_back('{1'b0, 3'b010, 32'h101, 32'h0,        32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b001, 32'h101, 32'h0,        32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b101, 32'h203, 32'h0,        32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b001, 32'h103, 32'h0000BBAA, 32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b1, 3'b010, 32'h102, 32'h33333333, 32'h00000000, 1'b1, 1, 4'h0, 32'h0,        32'h0});
    vq.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'hCAFEBEEF, 1'b0, 3, 4'h0, 32'h0,        32'h0});
`endif
    foreach (vq[i]) run_vec(vq[i], i);

    // Backpressure: LW held in RESP for 4 cycles while a store waits at the request port.
    @(negedge clk_20M);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h0;
    @(negedge clk_20M);
    req_we = 1'b1; req_addr = 32'h300; req_wdata = 32'h5A5A5A5A;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk_20M);
      n++;
    end
    check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp%0d_valid", c), {31'b0, resp_valid}, 32'd1);
      check($sformatf("bp%0d_rdata", c), resp_rdata, 32'h80017EFF);
      check($sformatf("bp%0d_req_ready", c), {31'b0, req_ready}, 32'd0);
      check($sformatf("bp%0d_wren", c), {28'b0, mem_wren}, 32'd0);
      @(negedge clk_20M);
    end
    resp_ready = 1'b1;
    @(negedge clk_20M);
    check("bp_rel_req_ready", {31'b0, req_ready}, 32'd1);
    check("bp_rel_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk_20M);
    req_valid = 1'b0;
    check("bp_next_wren", {28'b0, mem_wren}, 32'hF);
    check("bp_next_addr", mem_addr, 32'h300);
    check("bp_next_wdata", mem_wdata, 32'h5A5A5A5A);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk_20M);
      n++;
    end
    check("bp_next_done", {31'b0, resp_valid}, 32'd1);
    v = '{1'b0, 3'b010, 32'h300, 32'h0, 32'h5A5A5A5A, 1'b0, 3, 4'h0, 32'h0, 32'h0};
    run_vec(v, 100);

    // Reset asserted during ISSUE of a store: enable drops at once, RAM keeps the old word.
    v = '{1'b1, 3'b010, 32'h104, 32'h0BADF00D, 32'h0, 1'b0, 2, 4'hF, 32'h0BADF00D, 32'h104};
    run_vec(v, 101);
    @(negedge clk_20M);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h104; req_wdata = 32'h11111111;
    @(negedge clk_20M);
    req_valid = 1'b0;
    check("rs_issue_wren", {28'b0, mem_wren}, 32'hF);
    #5 rst_n = 1'b0;
    #1;
    check("rs_wren", {28'b0, mem_wren}, 32'd0);
    check("rs_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rs_req_ready", {31'b0, req_ready}, 32'd1);
    check("rs_mem_addr", mem_addr, 32'h0);
    @(negedge clk_20M);
    rst_n = 1'b1;
    check("rs_after_req_ready", {31'b0, req_ready}, 32'd1);
    v = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 1'b0, 3, 4'h0, 32'h0, 32'h0};
    run_vec(v, 102);

    @(negedge clk_20M);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
